// File: rtl/lockin_capture_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lockin_capture_writer                                         |
// | Purpose  : Captures a run of lock-in samples into a small FIFO and writes |
// |            them as 32-bit words at sequential RAM addresses when granted. |
// | Options  : LOCKIN_CAPTURE_DECIM_EN enables 1-of-(decim+1) decimation.     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module lockin_capture_writer #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    input  logic [15:0]       decim,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              ram_grant,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_req,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   c_FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] c_BASE     = ADDR_W'(BASE_ADDR);

    logic [1:0]        r_state;
    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]  r_wr_ptr;
    logic [c_PTR_W:0]  r_rd_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_length;
    logic [ADDR_W:0]   r_accepted;
    logic [ADDR_W:0]   r_wr_count;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_ram_write;
    logic [31:0]       r_ram_writedata;

    logic              w_empty;
    logic              w_full;
    logic              w_capture;
    logic              w_keep;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W:0]   w_accept_next;
    logic [31:0]       w_head;

`ifdef LOCKIN_CAPTURE_DECIM_EN
    logic [15:0] r_decim;
    logic [15:0] r_dec_cnt;
    assign w_keep = (r_dec_cnt == 16'd0);
`else
    logic w_unused_decim;
    assign w_unused_decim = ^decim;
    assign w_keep = 1'b1;
`endif

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_capture = (r_state == c_CAPTURE);
    assign w_head    = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_pop         = !w_empty && ram_grant && !abort;
    assign w_push        = w_capture && in_valid && w_keep && !abort && (!w_full || w_pop);
    assign w_drop        = w_capture && in_valid && w_keep && !abort && w_full && !w_pop;
    assign w_accept_next = r_accepted + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_ptr           <= c_BASE;
            r_length        <= '0;
            r_accepted      <= '0;
            r_wr_count      <= '0;
            r_overflow      <= 1'b0;
            r_ram_address   <= '0;
            r_ram_write     <= 1'b0;
            r_ram_writedata <= '0;
`ifdef LOCKIN_CAPTURE_DECIM_EN
            r_decim         <= '0;
            r_dec_cnt       <= '0;
`endif
        end else begin
            r_ram_address   <= '0;
            r_ram_write     <= 1'b0;
            r_ram_writedata <= '0;
            if (abort) begin
                r_state  <= c_IDLE;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_ram_address   <= r_ptr;
                    r_ram_write     <= 1'b1;
                    r_ram_writedata <= w_head;
                    r_rd_ptr        <= r_rd_ptr + 1'b1;
                    r_ptr           <= r_ptr + 1'b1;
                    r_wr_count      <= r_wr_count + 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_accepted <= w_accept_next;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
`ifdef LOCKIN_CAPTURE_DECIM_EN
                if (w_capture && in_valid) begin
                    r_dec_cnt <= (r_dec_cnt == r_decim) ? 16'd0 : r_dec_cnt + 16'd1;
                end
`endif
                case (r_state)
                    c_IDLE, c_DONE: begin
                        if (start) begin
                            r_state    <= c_CAPTURE;
                            r_length   <= (length == '0) ? c_FULL_LEN : length;
                            r_accepted <= '0;
                            r_wr_count <= '0;
                            r_overflow <= 1'b0;
                            r_ptr      <= c_BASE;
`ifdef LOCKIN_CAPTURE_DECIM_EN
                            r_decim    <= decim;
                            r_dec_cnt  <= '0;
`endif
                        end
                    end
                    c_CAPTURE: begin
                        if (w_push && (w_accept_next == r_length)) begin
                            r_state <= c_DRAIN;
                        end
                    end
                    c_DRAIN: begin
                        // Wait for the final strobe to retire before reporting done.
                        if (w_empty && !r_ram_write) begin
                            r_state <= c_DONE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign ram_address    = r_ram_address;
    assign ram_write      = r_ram_write;
    assign ram_chipselect = r_ram_write;
    assign ram_byteenable = {4{r_ram_write}};
    assign ram_writedata  = r_ram_writedata;
    assign ram_req        = !w_empty;
    assign busy           = (r_state == c_CAPTURE) || (r_state == c_DRAIN);
    assign done           = (r_state == c_DONE);
    assign wr_count       = r_wr_count;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lockin_capture_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lockin_capture_writer                                      |
// | Purpose  : Directed self-checking bench for lockin_capture_writer.        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lockin_capture_writer;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid, ram_grant;
    logic [10:0] length;
    logic [15:0] decim;
    logic [31:0] in_data;

    logic [9:0]  ram_address, h_address;
    logic [3:0]  ram_byteenable, h_byteenable;
    logic        ram_chipselect, h_chipselect, ram_write, h_write;
    logic [31:0] ram_writedata, h_writedata;
    logic        ram_req, h_req, busy, h_busy, done, h_done, overflow, h_overflow;
    logic [10:0] wr_count, h_wr_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lockin_capture_writer #(.ADDR_W(10), .FIFO_DEPTH(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
        .decim(decim), .in_valid(in_valid), .in_data(in_data), .ram_grant(ram_grant),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_req(ram_req), .busy(busy), .done(done),
        .wr_count(wr_count), .overflow(overflow)
    );

    lockin_capture_writer #(.ADDR_W(10), .FIFO_DEPTH(8), .BASE_ADDR(1020)) u_dut_hi (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
        .decim(decim), .in_valid(in_valid), .in_data(in_data), .ram_grant(ram_grant),
        .ram_address(h_address), .ram_byteenable(h_byteenable),
        .ram_chipselect(h_chipselect), .ram_write(h_write),
        .ram_writedata(h_writedata), .ram_req(h_req), .busy(h_busy), .done(h_done),
        .wr_count(h_wr_count), .overflow(h_overflow)
    );

    // Write logs, sampled mid-cycle.
    logic [9:0]  log_addr [256];
    logic [31:0] log_data [256];
    logic [3:0]  log_be   [256];
    logic        log_cs   [256];
    int          n_log = 0;
    logic [9:0]  hlog_addr [256];
    int          n_hlog = 0;

    always @(negedge clk) begin
        if (ram_write && n_log < 256) begin
            log_addr[n_log] = ram_address;
            log_data[n_log] = ram_writedata;
            log_be[n_log]   = ram_byteenable;
            log_cs[n_log]   = ram_chipselect;
            n_log++;
        end
        if (h_write && n_hlog < 256) begin
            hlog_addr[n_hlog] = h_address;
            n_hlog++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [10:0] len);
        length = len;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    int n0, h0;
    logic [31:0] exp_d [3];

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        ram_grant = 1'b0; length = '0; decim = '0; in_data = '0;
        tick(2);
        reset = 1'b0;
        chk("rst_write", ram_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", wr_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_req", ram_req, 0);

        // Basic 4-word capture with continuous grant
        ram_grant = 1'b1;
        n0 = n_log;
        pulse_start(11'd4);
        chk("t1_busy", busy, 1);
        in_valid = 1'b1;
        in_data = 32'h11; tick(1);
        in_data = 32'h22; tick(1);
        in_data = 32'h33; tick(1);
        in_data = 32'h44; tick(1);
        in_valid = 1'b0;
        tick(8);
        chk("t1_nwrites", n_log - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", log_addr[n0+i], i);
            chk("t1_data", log_data[n0+i], 32'h11 * (i + 1));
            chk("t1_be", log_be[n0+i], 4'hF);
            chk("t1_cs", log_cs[n0+i], 1);
        end
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_count", wr_count, 4);
        chk("t1_ovf", overflow, 0);

        // Overflow with grant held off
        ram_grant = 1'b0;
        n0 = n_log;
        pulse_start(11'd16);
        chk("t2_ovf_clear", overflow, 0);
        for (int i = 0; i < 12; i++) begin
            feed(32'h100 + i);
            if (i == 7) chk("t2_ovf_8", overflow, 0);
            if (i == 8) chk("t2_ovf_9", overflow, 1);
        end
        chk("t2_req", ram_req, 1);
        chk("t2_nowrite", n_log - n0, 0);
        ram_grant = 1'b1;
        tick(12);
        chk("t2_nwrites", n_log - n0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_addr", log_addr[n0+i], i);
            chk("t2_data", log_data[n0+i], 32'h100 + i);
        end
        chk("t2_busy", busy, 1);
        chk("t2_done", done, 0);
        chk("t2_count", wr_count, 8);
        chk("t2_ovf_sticky", overflow, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("t2_abort_busy", busy, 0);
        chk("t2_abort_ovf", overflow, 1);

        // Pointer wrap from BASE_ADDR=1020
        h0 = n_hlog;
        pulse_start(11'd8);
        for (int i = 0; i < 8; i++) feed(32'hA0 + i);
        tick(10);
        chk("t3_nwrites", n_hlog - h0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_addr", hlog_addr[h0+i], (1020 + i) % 1024);
        end
        chk("t3_count", h_wr_count, 8);
        chk("t3_done", h_done, 1);

        // Abort mid-capture
        n0 = n_log;
        pulse_start(11'd10);
        for (int i = 0; i < 3; i++) feed(32'hC0 + i);
        tick(3);
        chk("t4_three", n_log - n0, 3);
        ram_grant = 1'b0;
        feed(32'hC3);
        feed(32'hC4);
        chk("t4_req_pre", ram_req, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_req", ram_req, 0);
        chk("t4_write", ram_write, 0);
        chk("t4_count", wr_count, 3);
        ram_grant = 1'b1;
        tick(4);
        chk("t4_nomore", n_log - n0, 3);
        n0 = n_log;
        pulse_start(11'd1);
        chk("t4_count_clr", wr_count, 0);
        feed(32'h77);
        tick(5);
        chk("t4_re_n", n_log - n0, 1);
        chk("t4_re_addr", log_addr[n0], 0);
        chk("t4_re_data", log_data[n0], 32'h77);
        chk("t4_re_done", done, 1);

        // Decimation (or its absence in the default build)
        decim = 16'd2;
        n0 = n_log;
        pulse_start(11'd3);
`ifdef LOCKIN_CAPTURE_DECIM_EN
        for (int i = 1; i <= 9; i++) feed(i);
        exp_d[0] = 32'd1; exp_d[1] = 32'd4; exp_d[2] = 32'd7;
`else
        for (int i = 1; i <= 3; i++) feed(i);
        exp_d[0] = 32'd1; exp_d[1] = 32'd2; exp_d[2] = 32'd3;
`endif
        tick(6);
        chk("t5_nwrites", n_log - n0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_addr", log_addr[n0+i], i);
            chk("t5_data", log_data[n0+i], exp_d[i]);
        end
        chk("t5_done", done, 1);
        decim = 16'd0;

        // Reset during DRAIN
        ram_grant = 1'b0;
        pulse_start(11'd4);
        for (int i = 0; i < 4; i++) feed(32'hE0 + i);
        chk("t6_drain_busy", busy, 1);
        chk("t6_drain_req", ram_req, 1);
        ram_grant = 1'b1;
        tick(1);
        chk("t6_write_live", ram_write, 1);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("t6_addr", ram_address, 0);
        chk("t6_be", ram_byteenable, 0);
        chk("t6_cs", ram_chipselect, 0);
        chk("t6_write", ram_write, 0);
        chk("t6_wdata", ram_writedata, 0);
        chk("t6_req", ram_req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_count", wr_count, 0);
        chk("t6_ovf", overflow, 0);
        tick(2);
        chk("t6_idle_write", ram_write, 0);
        chk("t6_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
